// File: rtl/pipe_mux_n_pkg.sv
// pipe_mux_pkg: shared types and helpers for the pipe_mux_n registered selector.
//   pipe_mux_state_t : occupancy state of the output/skid register pair.
//   PIPE_MUX_MAX_IN  : largest supported input count.
//   sel_width(n)     : select width needed to index n inputs (never below 1).
package pipe_mux_pkg;

  localparam int PIPE_MUX_MAX_IN = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_mux_state_t;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipe_mux_n_sel.sv
// mux_sel_n: combinational selector over a flattened input bus.
//   data     in  NUM_IN*WIDTH  flattened inputs, lane k at data[k*WIDTH +: WIDTH]
//   sel      in  SEL_W         lane index
//   out      out WIDTH         selected lane, all zeros when sel is out of range
//   in_range out 1             sel < NUM_IN
module mux_sel_n
  import pipe_mux_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4
) (
  input  logic [NUM_IN*WIDTH-1:0]      data,
  input  logic [sel_width(NUM_IN)-1:0] sel,
  output logic [WIDTH-1:0]             out,
  output logic                         in_range
);

  always_comb begin
    out      = '0;
    in_range = (32'(sel) < 32'(NUM_IN));
    // One-hot OR over lanes; an unmatched select leaves the zero default.
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (32'(sel) == i) begin
        out = data[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/pipe_mux_n.sv
// pipe_mux_n: registered N-way operand selector with valid/ready handshake.
// Each accepted transfer captures in_data[in_sel] and in_sel. An output
// register plus a skid register give full throughput with in_ready driven
// straight from a flop.
//
// Optional feature macro: PIPE_MUX_SEL_CHECK_EN
//   defined   : out-of-range selects are consumed but dropped and raise the
//               sticky sel_err flag (cleared by err_clr; set wins).
//   undefined : out-of-range selects pass through with zero data; the
//               sel_err/err_clr ports are absent.
//
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   in_data     NUM_IN*WIDTH flattened inputs
//   in_sel      SEL_W input index for this transfer
//   in_valid    upstream offers a transfer
//   in_ready    block can accept (registered)
//   out_data    selected data
//   out_sel     select value that produced out_data
//   out_valid   output holds a transfer
//   out_ready   downstream accepts
//   sel_err     sticky out-of-range flag   (macro only)
//   err_clr     clears sel_err             (macro only)
module pipe_mux_n
  import pipe_mux_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = sel_width(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef PIPE_MUX_SEL_CHECK_EN
  ,
  output logic                    sel_err,
  input  logic                    err_clr
`endif
);

  pipe_mux_state_t state;

  logic [WIDTH-1:0] mux_data;
  logic             sel_ok;
  logic [WIDTH-1:0] cap_data;
  logic [WIDTH-1:0] sk_data;
  logic [SEL_W-1:0] sk_sel;
  logic             accept;
  logic             emit;
  logic             enq;

  mux_sel_n #(
    .WIDTH (WIDTH),
    .NUM_IN(NUM_IN)
  ) u_sel (
    .data    (in_data),
    .sel     (in_sel),
    .out     (mux_data),
    .in_range(sel_ok)
  );

  // Forced to zero for out-of-range selects regardless of the mux internals.
  assign cap_data = sel_ok ? mux_data : '0;

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

`ifdef PIPE_MUX_SEL_CHECK_EN
  // Bad selects are consumed (handshake completes) but never enqueued.
  assign enq = accept & sel_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_err <= 1'b0;
    end else if (accept && !sel_ok) begin
      sel_err <= 1'b1;
    end else if (err_clr) begin
      sel_err <= 1'b0;
    end
  end
`else
  assign enq = accept;
`endif

  // State, storage and both handshake outputs move together so in_ready and
  // out_valid are always registered copies of the next occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= '0;
      out_sel   <= '0;
      sk_data   <= '0;
      sk_sel    <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (enq) begin
            out_data  <= cap_data;
            out_sel   <= in_sel;
            out_valid <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (enq && emit) begin
            out_data <= cap_data;
            out_sel  <= in_sel;
          end else if (enq) begin
            sk_data  <= cap_data;
            sk_sel   <= in_sel;
            in_ready <= 1'b0;
            state    <= FULL;
          end else if (emit) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: begin
          if (emit) begin
            out_data <= sk_data;
            out_sel  <= sk_sel;
            in_ready <= 1'b1;
            state    <= BUSY;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_mux_n.sv
// tb_pipe_mux_n: directed self-checking bench for pipe_mux_n.
// DUT a: WIDTH=16, NUM_IN=4. DUT b: WIDTH=8, NUM_IN=3 (non-power-of-two).
// Expectations for the out-of-range cases follow PIPE_MUX_SEL_CHECK_EN.
module tb_pipe_mux_n;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  // DUT a
  logic [63:0] a_in_data;
  logic [1:0]  a_in_sel;
  logic        a_in_valid;
  logic        a_in_ready;
  logic [15:0] a_out_data;
  logic [1:0]  a_out_sel;
  logic        a_out_valid;
  logic        a_out_ready;

  // DUT b
  logic [23:0] b_in_data;
  logic [1:0]  b_in_sel;
  logic        b_in_valid;
  logic        b_in_ready;
  logic [7:0]  b_out_data;
  logic [1:0]  b_out_sel;
  logic        b_out_valid;
  logic        b_out_ready;

`ifdef PIPE_MUX_SEL_CHECK_EN
  logic a_sel_err, a_err_clr;
  logic b_sel_err, b_err_clr;
`endif

  pipe_mux_n #(.WIDTH(16), .NUM_IN(4)) dut_a (
    .clk      (clk),
    .reset    (reset),
    .in_data  (a_in_data),
    .in_sel   (a_in_sel),
    .in_valid (a_in_valid),
    .in_ready (a_in_ready),
    .out_data (a_out_data),
    .out_sel  (a_out_sel),
    .out_valid(a_out_valid),
    .out_ready(a_out_ready)
`ifdef PIPE_MUX_SEL_CHECK_EN
    ,
    .sel_err  (a_sel_err),
    .err_clr  (a_err_clr)
`endif
  );

  pipe_mux_n #(.WIDTH(8), .NUM_IN(3)) dut_b (
    .clk      (clk),
    .reset    (reset),
    .in_data  (b_in_data),
    .in_sel   (b_in_sel),
    .in_valid (b_in_valid),
    .in_ready (b_in_ready),
    .out_data (b_out_data),
    .out_sel  (b_out_sel),
    .out_valid(b_out_valid),
    .out_ready(b_out_ready)
`ifdef PIPE_MUX_SEL_CHECK_EN
    ,
    .sel_err  (b_sel_err),
    .err_clr  (b_err_clr)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    a_in_data   = '0;
    a_in_sel    = '0;
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    b_in_data   = {8'h33, 8'h22, 8'h11};
    b_in_sel    = '0;
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
`ifdef PIPE_MUX_SEL_CHECK_EN
    a_err_clr = 1'b0;
    b_err_clr = 1'b0;
`endif

    // Reset held for two cycles.
    tick();
    check("rst1_out_valid", 32'(a_out_valid), 32'd0);
    check("rst1_in_ready", 32'(a_in_ready), 32'd1);
    tick();
    check("rst2_out_valid", 32'(a_out_valid), 32'd0);
    check("rst2_in_ready", 32'(a_in_ready), 32'd1);
    check("rst_out_data", 32'(a_out_data), 32'd0);
    check("rst_out_sel", 32'(a_out_sel), 32'd0);
    check("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    reset = 1'b0;
    tick();
    check("post_rst_out_valid", 32'(a_out_valid), 32'd0);
    check("post_rst_in_ready", 32'(a_in_ready), 32'd1);

    // Single transfer, select 2.
    a_in_data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    a_in_sel   = 2'd2;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    check("single_out_valid", 32'(a_out_valid), 32'd1);
    check("single_out_data", 32'(a_out_data), 32'h3333);
    check("single_out_sel", 32'(a_out_sel), 32'd2);
    tick();
    check("single_drained", 32'(a_out_valid), 32'd0);

    // Streaming: transfer i presents lane k = 0x0100*i + k, select i%4.
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 4; k++) a_in_data[k*16 +: 16] = 16'(16'h0100 * i + k);
      a_in_sel   = 2'(i % 4);
      a_in_valid = 1'b1;
      tick();
      check($sformatf("stream%0d_valid", i), 32'(a_out_valid), 32'd1);
      check($sformatf("stream%0d_data", i), 32'(a_out_data), 32'(16'h0100 * i + (i % 4)));
      check($sformatf("stream%0d_sel", i), 32'(a_out_sel), 32'(i % 4));
      check($sformatf("stream%0d_ready", i), 32'(a_in_ready), 32'd1);
    end
    a_in_valid = 1'b0;
    tick();
    check("stream_drained", 32'(a_out_valid), 32'd0);

    // Backpressure: two accepts fill OR and SK.
    a_out_ready = 1'b0;
    a_in_data   = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    a_in_sel    = 2'd1;
    a_in_valid  = 1'b1;
    tick();
    check("bp1_in_ready", 32'(a_in_ready), 32'd1);
    check("bp1_out_data", 32'(a_out_data), 32'hA001);
    a_in_data = {16'hB003, 16'hB002, 16'hB001, 16'hB000};
    a_in_sel  = 2'd3;
    tick();
    check("bp2_in_ready", 32'(a_in_ready), 32'd0);
    check("bp2_out_valid", 32'(a_out_valid), 32'd1);
    check("bp2_out_data", 32'(a_out_data), 32'hA001);
    // Offer a third item that must not be taken while full.
    a_in_data = {16'hC003, 16'hC002, 16'hC001, 16'hC000};
    a_in_sel  = 2'd0;
    tick();
    check("bp3_in_ready", 32'(a_in_ready), 32'd0);
    check("bp3_out_data", 32'(a_out_data), 32'hA001);
    check("bp3_out_sel", 32'(a_out_sel), 32'd1);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    tick();
    check("bp4_out_data", 32'(a_out_data), 32'hB003);
    check("bp4_out_sel", 32'(a_out_sel), 32'd3);
    check("bp4_in_ready", 32'(a_in_ready), 32'd1);
    tick();
    check("bp5_out_valid", 32'(a_out_valid), 32'd0);

    // Mid-operation reset while full.
    a_out_ready = 1'b0;
    a_in_data   = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
    a_in_sel    = 2'd2;
    a_in_valid  = 1'b1;
    tick();
    tick();
    check("mr_full_in_ready", 32'(a_in_ready), 32'd0);
    reset       = 1'b1;
    a_out_ready = 1'b1;
    tick();
    check("mr_out_valid", 32'(a_out_valid), 32'd0);
    check("mr_in_ready", 32'(a_in_ready), 32'd1);
    check("mr_out_data", 32'(a_out_data), 32'd0);
    reset      = 1'b0;
    a_in_valid = 1'b0;
    tick();
    check("mr_no_stale", 32'(a_out_valid), 32'd0);
    tick();
    check("mr_no_stale2", 32'(a_out_valid), 32'd0);

    // Non-power-of-two: out-of-range select 3, then valid select 1.
    b_in_sel   = 2'd3;
    b_in_valid = 1'b1;
    tick();
`ifdef PIPE_MUX_SEL_CHECK_EN
    check("b_oor_dropped", 32'(b_out_valid), 32'd0);
    check("b_oor_in_ready", 32'(b_in_ready), 32'd1);
    check("b_sel_err_set", 32'(b_sel_err), 32'd1);
`else
    check("b_oor_valid", 32'(b_out_valid), 32'd1);
    check("b_oor_data", 32'(b_out_data), 32'd0);
    check("b_oor_sel", 32'(b_out_sel), 32'd3);
`endif
    b_in_sel = 2'd1;
    tick();
    b_in_valid = 1'b0;
    check("b_ok_valid", 32'(b_out_valid), 32'd1);
    check("b_ok_data", 32'(b_out_data), 32'h22);
    check("b_ok_sel", 32'(b_out_sel), 32'd1);
    tick();
    check("b_drained", 32'(b_out_valid), 32'd0);
`ifdef PIPE_MUX_SEL_CHECK_EN
    check("b_sel_err_hold", 32'(b_sel_err), 32'd1);
    // New error together with clear: set wins.
    b_in_sel   = 2'd3;
    b_in_valid = 1'b1;
    b_err_clr  = 1'b1;
    tick();
    b_in_valid = 1'b0;
    check("b_sel_err_set_wins", 32'(b_sel_err), 32'd1);
    check("b_set_wins_no_out", 32'(b_out_valid), 32'd0);
    tick();
    check("b_sel_err_cleared", 32'(b_sel_err), 32'd0);
    b_err_clr = 1'b0;
    tick();
    check("b_sel_err_stays_clear", 32'(b_sel_err), 32'd0);
    check("a_sel_err_clean", 32'(a_sel_err), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_mux_n.md
# pipe_mux_n

Parametrised, registered N-way operand selector for the datapath. It replaces fixed 4-input 16-bit selection wherever a pipeline stage boundary is needed, e.g. ALU operand and writeback-source selection. Each transfer carries its own select value through a valid/ready handshake. A 2-entry skid buffer gives full throughput with registered `in_ready`.

## Interface
Reset is synchronous and active-high. There is one clock, `clk`.

Parameters:
- `WIDTH`, 16: data bits per input.
- `NUM_IN`, 4: number of inputs. Legal range is 2..16; any integer in that range is allowed.
- `SEL_W`, `$clog2(NUM_IN)`: select width. Derived; do not override.

Ports:
- `clk`  in  1  clock. Everything is sampled on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  `NUM_IN*WIDTH`  flattened inputs. Input k is `in_data[k*WIDTH +: WIDTH]`.
- `in_sel`  in  `SEL_W`  input index for this transfer.
- `in_valid`  in  1  upstream offers a transfer.
- `in_ready`  out  1  block accepts a transfer. Driven directly from a register.
- `out_data`  out  `WIDTH`  selected data.
- `out_sel`  out  `SEL_W`  select value that produced `out_data`.
- `out_valid`  out  1  output holds a transfer.
- `out_ready`  in  1  downstream accepts.
- `sel_err`  out  1  sticky out-of-range flag. Present only with `PIPE_MUX_SEL_CHECK_EN`.
- `err_clr`  in  1  clears `sel_err`. Present only with `PIPE_MUX_SEL_CHECK_EN`.

## Operation
- Accept occurs when `in_valid & in_ready`. Selection `in_data[in_sel]` and `in_sel` are captured on that edge.
- Emit occurs when `out_valid & out_ready`.
- Storage is an output register (OR) plus a skid register (SK).
- State machine:
  - EMPTY: `out_valid`=0, `in_ready`=1.
    - Accept → BUSY, writing OR.
  - BUSY: `out_valid`=1, `in_ready`=1.
    - Accept and emit → BUSY, with OR replaced by new data.
    - Accept only → FULL, writing SK.
    - Emit only → EMPTY.
  - FULL: `out_valid`=1, `in_ready`=0.
    - Emit → BUSY, moving SK into OR.
    - No accept is possible in this state.
- Transfer order is strictly preserved. No transfer is dropped or duplicated, except under the select check described in Configuration.
- `out_data` and `out_sel` are stable while `out_valid & !out_ready` holds.
- Out-of-range select (`in_sel >= NUM_IN`, possible only when `NUM_IN` is not a power of two) without the macro: the transfer proceeds with `out_data` = 0.
- `in_data` is don't-care when not accepting. `out_data` is don't-care while `out_valid`=0, but must not be X after reset.

## Timing
- Latency is 1 cycle: data accepted at edge t is visible on `out_*` after edge t, provided OR was empty or being emitted.
- Throughput is 1 transfer per cycle while `out_ready`=1.
- `in_ready` falls the cycle after the skid fills and rises the cycle after the first emit from FULL.
- Reset values: state EMPTY, `out_valid`=0, `in_ready`=1, `out_data`=0, `out_sel`=0, `sel_err`=0.
- Reset asserted mid-operation discards OR and SK contents at that edge. Handshakes are ignored during the reset cycle.
- `in_ready` must not depend combinationally on `out_ready`.

## Configuration
- `PIPE_MUX_SEL_CHECK_EN` defined:
  - An accept with an out-of-range `in_sel` is consumed but not enqueued: state is unchanged and `in_ready` behaves normally.
  - `sel_err` is set on the following edge.
  - `err_clr`=1 clears `sel_err` on the next edge. If a new error and `err_clr` occur in the same cycle, set wins.
- Undefined: the `sel_err` and `err_clr` ports do not exist, and out-of-range transfers emit data 0 as described above.

## Structure
- Shared package `pipe_mux_pkg`:
  - State enum `{EMPTY, BUSY, FULL}`.
  - `PIPE_MUX_MAX_IN` = 16.
  - Function `sel_width(n)`.
- Sub-module `mux_sel_n` (parameters `WIDTH`, `NUM_IN`): combinational flattened-bus selector with an in-range flag output. It is instantiated once on the input side.
- The top level holds the FSM, OR, SK and error logic.

## Test plan
- **Reset and single transfer.** Hold reset 2 cycles, then send `in_sel`=2 with `in_data` lanes {0x1111, 0x2222, 0x3333, 0x4444}.
  - During and after reset: `out_valid`=0, `in_ready`=1.
  - One cycle after the accept: `out_data`=0x3333, `out_sel`=2.
- **Streaming.** Send 8 back-to-back transfers with `out_ready`=1 and cycling select values.
  - One output per cycle, in order, with 1-cycle latency.
- **Backpressure.** Drop `out_ready` while streaming.
  - After 2 accepts: `in_ready`=0 and the state holds FULL.
  - Restore `out_ready`: both held items emerge in order, then `in_ready` returns to 1.
- **Mid-operation reset.** Assert reset while in FULL.
  - The next cycle: `out_valid`=0, `in_ready`=1, with no stale output after release.
- **Non-power-of-two, macro off.** With `NUM_IN`=3, send `in_sel`=3.
  - `out_valid` pulses with `out_data`=0.
- **Non-power-of-two, macro on.** With `NUM_IN`=3 and `PIPE_MUX_SEL_CHECK_EN`, send `in_sel`=3 followed by a valid `in_sel`=1.
  - Only the `in_sel`=1 data appears at the output.
  - `sel_err`=1 and holds until `err_clr`; asserting `err_clr` together with a new error leaves it at 1.
